cacheline_adaptor: RTL

CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

---
 rtl/cacheline_adaptor.sv | 119 +++++++++++
 1 files changed

// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cache line port to a 64-bit, four-beat physical memory burst port.
// It assembles read beats into a fill line and slices a latched line into write beats.
module cacheline_adaptor (
   input  logic         clk,
   input  logic         rst,

   input  logic [255:0] line_i,
   output logic [255:0] line_o,
   input  logic [31:0]  address_i,
   input  logic         read_i,
   input  logic         write_i,
   output logic         resp_o,

   input  logic [63:0]  burst_i,
   output logic [63:0]  burst_o,
   output logic [31:0]  address_o,
   output logic         read_o,
   output logic         write_o,
   input  logic         resp_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      WR   = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t       state;
   state_t       state_nxt;
   logic [1:0]   cnt;
   logic [31:0]  addr_q;
   logic [255:0] wline_q;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; a simultaneous read and write resolves to the write
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (write_i) begin
               state_nxt = WR;
            end else if (read_i) begin
               state_nxt = RD;
            end
         end
         RD: begin
            if (resp_i && (cnt == 2'd3)) begin
               state_nxt = DONE;
            end
         end
         WR: begin
            if (resp_i && (cnt == 2'd3)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Datapath: request latch, beat counter and fill-line assembly
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= 2'd0;
         addr_q  <= 32'd0;
         wline_q <= 256'd0;
         line_o  <= 256'd0;
      end else begin
         case (state)
            IDLE: begin
               if (write_i) begin
                  wline_q <= line_i;
                  addr_q  <= {address_i[31:5], 5'b0};
                  cnt     <= 2'd0;
               end else if (read_i) begin
                  addr_q  <= {address_i[31:5], 5'b0};
                  cnt     <= 2'd0;
               end
            end
            RD: begin
               if (resp_i) begin
                  line_o[{cnt, 6'b0} +: 64] <= burst_i;
                  cnt <= cnt + 2'd1;
               end
            end
            WR: begin
               if (resp_i) begin
                  cnt <= cnt + 2'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs decoded from registered state only
   always_comb begin
      read_o    = (state == RD);
      write_o   = (state == WR);
      resp_o    = (state == DONE);
      address_o = addr_q;
      burst_o   = wline_q[{cnt, 6'b0} +: 64];
   end

endmodule
